// File: rtl/iopmp_check_arbiter.sv
// iopmp_check_arbiter: round-robin share of one IOPMP rule checker.
// Optional watchdog in WAIT: define IOPMP_ARB_TIMEOUT_EN.
//
// Ports:
//   req_*_i / req_ready_o : per-channel check requests (packed per chan)
//   rsp_*_o               : per-channel one-cycle result pulse
//   chk_*_o / chk_ready_i : single issue port to the checker
//   chk_rsp_*_i           : checker result (sampled in WAIT only)
//   busy_o, timeout_o     : status; timeout_o pulses with a watchdog RESP

package iopmp_arb_pkg;
  localparam int unsigned SourceWidth = 8;

  typedef enum logic {
    IOPMP_ACC_READ  = 1'b0,
    IOPMP_ACC_WRITE = 1'b1
  } iopmp_req_e;
endpackage

module iopmp_check_arbiter
  import iopmp_arb_pkg::*;
#(
  parameter int unsigned IOPMPNumChan  = 2,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [IOPMPNumChan-1:0]        req_valid_i,
  input  logic [IOPMPNumChan-1:0][33:0]  req_addr_i,
  input  iopmp_req_e [IOPMPNumChan-1:0]  req_access_i,
  output logic [IOPMPNumChan-1:0]        req_ready_o,
  output logic [IOPMPNumChan-1:0]        rsp_valid_o,
  output logic [IOPMPNumChan-1:0]        rsp_denied_o,
  output logic [IOPMPNumChan-1:0][8:0]   rsp_entry_idx_o,
  output logic                           chk_valid_o,
  input  logic                           chk_ready_i,
  output logic [33:0]                    chk_addr_o,
  output iopmp_req_e                     chk_access_o,
  output logic [SourceWidth-1:0]         chk_rrid_o,
  input  logic                           chk_rsp_valid_i,
  input  logic                           chk_denied_i,
  input  logic [8:0]                     chk_entry_idx_i,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int unsigned PtrW = $clog2(IOPMPNumChan);

  if (IOPMPNumChan < 2 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("iopmp_check_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state_d, state_q;
  logic [PtrW-1:0]   rr_ptr_d, rr_ptr_q;
  logic [PtrW-1:0]   gnt_idx_d, gnt_idx_q;
  logic [33:0]       addr_d, addr_q;
  iopmp_req_e        acc_d, acc_q;
  logic              denied_d, denied_q;
  logic [8:0]        eidx_d, eidx_q;

  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [PtrW-1:0]   cand;

`ifdef IOPMP_ARB_TIMEOUT_EN
  localparam int unsigned CntW =
    (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic              timeout_d, timeout_q;
`endif

  // First requester at or after rr_ptr, wrapping modulo the channel count.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < IOPMPNumChan; i++) begin
      cand = PtrW'((32'(rr_ptr_q) + i) % IOPMPNumChan);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    denied_d  = denied_q;
    eidx_d    = eidx_q;
`ifdef IOPMP_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_idx_d = win_idx;
          addr_d    = req_addr_i[win_idx];
          acc_d     = req_access_i[win_idx];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (chk_ready_i) begin
          state_d = ST_WAIT;
`ifdef IOPMP_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        // A real result beats a same-cycle watchdog expiry.
        if (chk_rsp_valid_i) begin
          denied_d = chk_denied_i;
          eidx_d   = chk_entry_idx_i;
          state_d  = ST_RESP;
        end
`ifdef IOPMP_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          denied_d  = 1'b1;
          eidx_d    = 9'h000;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (gnt_idx_q == PtrW'(IOPMPNumChan - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gnt_idx_q + PtrW'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      acc_q     <= IOPMP_ACC_READ;
      denied_q  <= 1'b0;
      eidx_q    <= '0;
`ifdef IOPMP_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      denied_q  <= denied_d;
      eidx_q    <= eidx_d;
`ifdef IOPMP_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Grant is gated by rst_ni so every output is quiet while in reset.
  always_comb begin
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    rsp_denied_o    = '0;
    rsp_entry_idx_o = '0;
    if (rst_ni && state_q == ST_IDLE && win_found) begin
      req_ready_o[win_idx] = 1'b1;
    end
    if (state_q == ST_RESP) begin
      rsp_valid_o[gnt_idx_q]     = 1'b1;
      rsp_denied_o[gnt_idx_q]    = denied_q;
      rsp_entry_idx_o[gnt_idx_q] = eidx_q;
    end
  end

  assign chk_valid_o  = (state_q == ST_ISSUE);
  assign chk_addr_o   = chk_valid_o ? addr_q : '0;
  assign chk_access_o = chk_valid_o ? acc_q : IOPMP_ACC_READ;
  assign chk_rrid_o   = chk_valid_o ? SourceWidth'(gnt_idx_q) : '0;
  assign busy_o       = (state_q != ST_IDLE);

`ifdef IOPMP_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// tb_iopmp_check_arbiter: scenario tasks with a response scoreboard.
// Honours IOPMP_ARB_TIMEOUT_EN for the watchdog scenario.
module tb_iopmp_check_arbiter;
  import iopmp_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       req_valid;
  logic [N-1:0][33:0] req_addr;
  iopmp_req_e [N-1:0] req_access;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_denied;
  logic [N-1:0][8:0]  rsp_idx;
  logic               chk_valid;
  logic               chk_ready;
  logic [33:0]        chk_addr;
  iopmp_req_e         chk_access;
  logic [SourceWidth-1:0] chk_rrid;
  logic               chk_rsp_valid;
  logic               chk_denied;
  logic [8:0]         chk_idx;
  logic               busy;
  logic               timeout;

  typedef struct {
    int         ch;
    logic       denied;
    logic [8:0] idx;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  iopmp_check_arbiter #(
    .IOPMPNumChan (N),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_access_i   (req_access),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_denied_o   (rsp_denied),
    .rsp_entry_idx_o(rsp_idx),
    .chk_valid_o    (chk_valid),
    .chk_ready_i    (chk_ready),
    .chk_addr_o     (chk_addr),
    .chk_access_o   (chk_access),
    .chk_rrid_o     (chk_rrid),
    .chk_rsp_valid_i(chk_rsp_valid),
    .chk_denied_i   (chk_denied),
    .chk_entry_idx_i(chk_idx),
    .busy_o         (busy),
    .timeout_o      (timeout)
  );

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_addr  = '0;
    for (int i = 0; i < N; i++) req_access[i] = IOPMP_ACC_READ;
    chk_ready     = 1'b0;
    chk_rsp_valid = 1'b0;
    chk_denied    = 1'b0;
    chk_idx       = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_valid     = '1;
    chk_rsp_valid = 1'b1;
    rst_n         = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, rsp_denied, rsp_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %0h want 0",
               {req_ready, rsp_valid, rsp_denied, rsp_idx});
    end
    n_tests++;
    if ({chk_valid, chk_addr, chk_rrid, busy, timeout} !== '0 ||
        chk_access !== IOPMP_ACC_READ) begin
      n_fail++;
      $display("FAIL reset_chk: got %0h want 0",
               {chk_valid, chk_addr, chk_rrid, busy, timeout});
    end
    apply_reset();
    @(negedge clk);
    n_tests++;
    if ({busy, req_ready, chk_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0h want 0",
               {busy, req_ready, chk_valid});
    end
  endtask

  task automatic test_single();
    exp_t e;
    drv();
    req_valid[0]  = 1'b1;
    req_addr[0]   = 34'h0_8000_0000;
    req_access[0] = IOPMP_ACC_READ;
    chk_ready     = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t0: got rdy=%b busy=%b want 01/0",
               req_ready, busy);
    end
    sb.push_back('{0, 1'b0, 9'h000});
    drv();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (chk_valid !== 1'b1 || chk_rrid !== 0 ||
        chk_addr !== 34'h0_8000_0000) begin
      n_fail++;
      $display("FAIL single_t1: got v=%b rrid=%0d a=%h want 1/0/80000000",
               chk_valid, chk_rrid, chk_addr);
    end
    drv();
    chk_rsp_valid = 1'b1;
    chk_denied    = 1'b0;
    chk_idx       = 9'h000;
    @(negedge clk);
    n_tests++;
    if (chk_valid !== 1'b0 || rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_t2: got v=%b rsp=%b want 0/00",
               chk_valid, rsp_valid);
    end
    drv();
    chk_rsp_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_denied[e.ch] !== e.denied ||
        rsp_idx[e.ch] !== e.idx) begin
      n_fail++;
      $display("FAIL single_t3: got v=%b d=%b want 01/%b",
               rsp_valid, rsp_denied, e.denied);
    end
    drv();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t4: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int ngr;
    int nrsp;
    int last;
    int g;
    apply_reset();
    chk_ready     = 1'b1;
    chk_rsp_valid = 1'b1;
    chk_denied    = 1'b0;
    req_addr[0]   = 34'h0_0000_1000;
    req_addr[1]   = 34'h1_0000_2000;
    req_valid     = 2'b11;
    ngr  = 0;
    nrsp = 0;
    last = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready[1] ? 1 : 0;
        n_tests++;
        if (g != ngr % 2) begin
          n_fail++;
          $display("FAIL rr_order: got ch%0d want ch%0d", g, ngr % 2);
        end
        if (ngr > 0) begin
          n_tests++;
          if (c - last != 4) begin
            n_fail++;
            $display("FAIL rr_spacing: got %0d want 4", c - last);
          end
        end
        last = c;
        sb.push_back('{ngr % 2, 1'b0, 9'(9'h100 + ngr % 2)});
        ngr++;
      end
      if (chk_valid) chk_idx = 9'h100 | 9'(chk_rrid);
      if (rsp_valid != '0) begin
        n_tests++;
        if ($countones(rsp_valid) != 1 || sb.size() == 0) begin
          n_fail++;
          $display("FAIL rr_onehot: got %b want one-hot", rsp_valid);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (rsp_valid[e.ch] !== 1'b1 || rsp_idx[e.ch] !== e.idx) begin
            n_fail++;
            $display("FAIL rr_rsp: got v=%b idx=%h want ch%0d/%h",
                     rsp_valid, rsp_idx[e.ch], e.ch, e.idx);
          end
        end
        nrsp++;
      end
    end
    n_tests++;
    if (nrsp != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want 4", nrsp);
    end
    req_valid     = '0;
    chk_rsp_valid = 1'b0;
  endtask

  task automatic test_denial();
    exp_t e;
    drv();
    req_valid[1]  = 1'b1;
    req_addr[1]   = 34'h2_1234_5678;
    req_access[1] = IOPMP_ACC_WRITE;
    chk_ready     = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL deny_grant: got %b want 10", req_ready);
    end
    drv();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (chk_valid !== 1'b1 || chk_access !== IOPMP_ACC_WRITE ||
        chk_rrid !== 1 || chk_addr !== 34'h2_1234_5678) begin
      n_fail++;
      $display("FAIL deny_issue: got acc=%0d rrid=%0d a=%h want 1/1/212345678",
               chk_access, chk_rrid, chk_addr);
    end
    sb.push_back('{1, 1'b1, 9'h103});
    drv();
    chk_rsp_valid = 1'b1;
    chk_denied    = 1'b1;
    chk_idx       = 9'h103;
    @(negedge clk);
    drv();
    chk_rsp_valid = 1'b0;
    chk_denied    = 1'b0;
    chk_idx       = '0;
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 2'b10 || rsp_denied[e.ch] !== e.denied ||
        rsp_idx[e.ch] !== e.idx) begin
      n_fail++;
      $display("FAIL deny_rsp: got v=%b d=%b idx=%h want 10/1/103",
               rsp_valid, rsp_denied, rsp_idx[1]);
    end
    n_tests++;
    if (rsp_denied[0] !== 1'b0 || rsp_idx[0] !== 9'h0) begin
      n_fail++;
      $display("FAIL deny_ch0: got d=%b idx=%h want 0/0",
               rsp_denied[0], rsp_idx[0]);
    end
    req_access[1] = IOPMP_ACC_READ;
  endtask

  task automatic test_backpressure();
    exp_t e;
    drv();
    req_valid   = 2'b11;
    req_addr[0] = 34'h1_0000_0040;
    req_addr[1] = 34'h3_0000_0080;
    chk_ready   = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: got %b want 01", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      drv();
      @(negedge clk);
      n_tests++;
      if (chk_valid !== 1'b1 || chk_addr !== 34'h1_0000_0040 ||
          chk_rrid !== 0 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%b a=%h rrid=%0d rdy=%b cyc=%0d",
                 chk_valid, chk_addr, chk_rrid, req_ready, k);
      end
    end
    drv();
    chk_ready    = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (chk_valid !== 1'b1 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_hs: got v=%b rdy=%b want 1/00",
               chk_valid, req_ready);
    end
    sb.push_back('{0, 1'b0, 9'h1AA});
    drv();
    chk_rsp_valid = 1'b1;
    chk_idx       = 9'h1AA;
    @(negedge clk);
    drv();
    chk_rsp_valid = 1'b0;
    chk_idx       = '0;
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_idx[e.ch] !== e.idx ||
        rsp_denied[e.ch] !== e.denied) begin
      n_fail++;
      $display("FAIL bp_rsp: got v=%b idx=%h want 01/1aa",
               rsp_valid, rsp_idx[0]);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    drv();
    req_valid[0] = 1'b1;
    req_addr[0]  = 34'h3_FFFF_FFFC;
    chk_ready    = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL to_grant: got %b want 01", req_ready);
    end
    drv();
    req_valid = '0;
    @(negedge clk);
`ifdef IOPMP_ARB_TIMEOUT_EN
    begin
      exp_t e;
      sb.push_back('{0, 1'b1, 9'h000});
      for (int w = 0; w < TO; w++) begin
        drv();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL to_wait: got b=%b v=%b t=%b cyc=%0d",
                   busy, rsp_valid, timeout, w);
        end
      end
      drv();
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (timeout !== 1'b1 || rsp_valid !== 2'b01 ||
          rsp_denied[e.ch] !== e.denied || rsp_idx[e.ch] !== e.idx) begin
        n_fail++;
        $display("FAIL to_expire: got t=%b v=%b d=%b idx=%h want 1/01/1/0",
                 timeout, rsp_valid, rsp_denied, rsp_idx[0]);
      end
      drv();
      @(negedge clk);
      n_tests++;
      if (timeout !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL to_after: got t=%b b=%b want 0/0", timeout, busy);
      end
    end
`else
    for (int w = 0; w < 30; w++) begin
      drv();
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || rsp_valid !== 2'b00 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hang: got b=%b v=%b t=%b cyc=%0d",
                 busy, rsp_valid, timeout, w);
      end
    end
    apply_reset();
`endif
  endtask

  task automatic test_async_reset();
    exp_t e;
    // Complete a ch0 check so rr_ptr points at ch1 before the reset.
    drv();
    req_valid[0] = 1'b1;
    req_addr[0]  = 34'h0_0000_0100;
    chk_ready    = 1'b1;
    @(negedge clk);
    sb.push_back('{0, 1'b0, 9'h055});
    drv();
    req_valid = '0;
    drv();
    chk_rsp_valid = 1'b1;
    chk_idx       = 9'h055;
    drv();
    chk_rsp_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_idx[e.ch] !== e.idx) begin
      n_fail++;
      $display("FAIL ar_pre: got v=%b idx=%h want 01/055",
               rsp_valid, rsp_idx[0]);
    end
    drv();
    req_valid[1] = 1'b1;
    req_addr[1]  = 34'h2_0000_0200;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL ar_grant1: got %b want 10", req_ready);
    end
    drv();
    req_valid = '0;
    drv();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || chk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_wait: got b=%b v=%b want 1/0", busy, chk_valid);
    end
    #1;
    rst_n         = 1'b0;
    req_valid     = 2'b11;
    chk_rsp_valid = 1'b1;
    chk_idx       = 9'h1FF;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_denied, rsp_idx, chk_valid,
         chk_addr, chk_rrid, busy, timeout} !== '0) begin
      n_fail++;
      $display("FAIL ar_zero: got rdy=%b v=%b b=%b t=%b",
               req_ready, rsp_valid, busy, timeout);
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ar_norsp: got v=%b b=%b cyc=%0d",
                 rsp_valid, busy, k);
      end
      drv();
    end
    req_valid   = 2'b11;
    req_addr[0] = 34'h0_0000_0300;
    chk_idx     = 9'h0AB;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL ar_rrptr: got %b want 01", req_ready);
    end
    sb.push_back('{0, 1'b0, 9'h0AB});
    drv();
    req_valid = '0;
    drv();
    drv();
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_idx[e.ch] !== e.idx) begin
      n_fail++;
      $display("FAIL ar_post: got v=%b idx=%h want 01/0ab",
               rsp_valid, rsp_idx[0]);
    end
    chk_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_denial();
    test_backpressure();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iopmp_check_arbiter.md
# iopmp_check_arbiter

- Round-robin arbiter that shares one IOPMP rule-checker among `IOPMPNumChan` TL-UL request handlers.
- Each handler posts an address/access check; the arbiter serialises the checks onto the single checker port, keeps one check outstanding, and returns the permission result to the requesting channel.
- It sits between the per-channel request handlers and the IOPMP entry-match logic. It replaces per-channel checker instances.

## Interface
Parameters:
- `IOPMPNumChan`, 2: number of requesting channels (≥2).
- `TimeoutCycles`, 16: watchdog limit in WAIT. Used only with `IOPMP_ARB_TIMEOUT_EN`. Must be ≥1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i[IOPMPNumChan]` in 1: channel requests a check.
- `req_addr_i[IOPMPNumChan]` in 34: address to check.
- `req_access_i[IOPMPNumChan]` in `iopmp_req_e`: `IOPMP_ACC_READ` or `IOPMP_ACC_WRITE`.
- `req_ready_o[IOPMPNumChan]` out 1: request accepted this cycle.
- `rsp_valid_o[IOPMPNumChan]` out 1: result pulse for the channel.
- `rsp_denied_o[IOPMPNumChan]` out 1: permission denied.
- `rsp_entry_idx_o[IOPMPNumChan]` out 9: violated-entry index. Bit 8 set means an entry matched.
- `chk_valid_o` out 1: check issued to the checker.
- `chk_ready_i` in 1: checker accepts the issued check.
- `chk_addr_o` out 34: address to the checker.
- `chk_access_o` out `iopmp_req_e`: access type to the checker.
- `chk_rrid_o` out `SourceWidth`: rrid, equal to the granted channel index.
- `chk_rsp_valid_i` in 1: checker result valid.
- `chk_denied_i` in 1: checker result, denied.
- `chk_entry_idx_i` in 9: checker violated-entry index.
- `busy_o` out 1: state ≠ IDLE.
- `timeout_o` out 1: one-cycle pulse on a watchdog expiry.

## Operation
States are IDLE, ISSUE, WAIT, RESP.

Registers:
- `rr_ptr`, width `$clog2(IOPMPNumChan)`.
- `gnt_idx`.
- Latched address, access and result.

IDLE:
- Search channels `rr_ptr, rr_ptr+1, …` modulo `IOPMPNumChan`. The first channel with `req_valid_i` set wins.
- Assert `req_ready_o[win]` combinationally in the same cycle.
- Latch the winner's address and access, set `gnt_idx = win`, and go to ISSUE.
- With no request present, stay in IDLE.

ISSUE:
- `chk_valid_o = 1`, driving the latched address/access and `chk_rrid_o = gnt_idx`.
- Go to WAIT on the cycle with `chk_valid_o && chk_ready_i`.
- The payload is held stable until that handshake.

WAIT:
- When `chk_rsp_valid_i` is set, latch `chk_denied_i` and `chk_entry_idx_i`, then go to RESP.
- `chk_rsp_valid_i` is ignored in any state other than WAIT.

RESP:
- For one cycle: `rsp_valid_o[gnt_idx] = 1`, with the latched denied flag and entry index.
- Set `rr_ptr = (gnt_idx+1) mod IOPMPNumChan` and return to IDLE.

Other rules:
- Only one check is outstanding at a time. Non-granted channels see `req_ready_o = 0` and must hold their request.
- A requester may drop `req_valid_i` before it is granted. After the grant it must not drop it, because the payload is already latched.
- `rsp_denied_o` and `rsp_entry_idx_o` are 0 on every channel that is not granted, and 0 on all channels outside RESP.
- `rr_ptr` wraps from `IOPMPNumChan-1` to 0.

## Timing
- Reset: state IDLE, `rr_ptr = 0`, `gnt_idx = 0`. Every output is 0, including `req_ready_o`, `chk_valid_o`, `busy_o` and `timeout_o`.
- Reset assertion mid-operation aborts the outstanding check immediately. No response is delivered afterwards.
- Minimum latency, with `chk_ready_i` and `chk_rsp_valid_i` both high at first opportunity:
  - T0: accept.
  - T1: issue handshake.
  - T2: checker result.
  - T3: `rsp_valid_o`.
- Back-to-back: the next grant is possible at T4, i.e. one check per 4 cycles.
- A RESP cycle and a new request in the same cycle: the new request is granted in the following IDLE cycle, using the updated `rr_ptr`.

## Configuration
`IOPMP_ARB_TIMEOUT_EN`

Defined:
- A counter clears on entry to WAIT and increments each WAIT cycle.
- If `TimeoutCycles` cycles pass without `chk_rsp_valid_i`, go to RESP with `denied = 1`, `entry_idx = 9'h000`, and pulse `timeout_o` for one cycle (the WAIT→RESP transition).
- A `chk_rsp_valid_i` arriving on the same cycle as expiry wins, and `timeout_o` stays 0.

Undefined:
- No counter. WAIT is indefinite and `timeout_o` is tied to 0.

## Test plan
1. **Single request.**
   - Stimulus: ch0 requests addr `34'h0_8000_0000`, READ. Checker answers with `denied = 0`, idx `9'h000` one cycle after the issue handshake.
   - Required: `req_ready_o[0]` at T0, `chk_rrid_o = 0` at T1, `rsp_valid_o[0] = 1` with `rsp_denied_o = 0` at T3, `busy_o = 0` at T4.
2. **Round robin.**
   - Stimulus: ch0 and ch1 both request continuously from reset.
   - Required: grant order 0,1,0,1. `rsp_valid_o` never asserts on both channels in the same cycle.
3. **Denial propagation.**
   - Stimulus: ch1 WRITE; checker returns `denied = 1`, idx `9'h103`.
   - Required: `chk_access_o = IOPMP_ACC_WRITE`; `rsp_denied_o[1] = 1`, `rsp_entry_idx_o[1] = 9'h103`; ch0 outputs stay 0.
4. **Backpressure.**
   - Stimulus: hold `chk_ready_i = 0` for 5 cycles in ISSUE.
   - Required: `chk_valid_o`, address and rrid are stable throughout. No extra `req_ready_o` pulses occur.
5. **Timeout (macro defined, `TimeoutCycles = 4`).**
   - Stimulus: the checker never responds.
   - Required: after 4 WAIT cycles, `timeout_o` pulses, `rsp_denied_o = 1`, idx `9'h000`. With the macro undefined, `busy_o` stays 1 indefinitely.
6. **Async reset mid-WAIT.**
   - Stimulus: assert `rst_ni = 0` while in WAIT.
   - Required: all outputs are 0 immediately, with no response afterwards. After release, a new ch0 request is granted with `rr_ptr = 0`.
